inv_chain_seq: RTL and testbench

- Clocked sequencer that drives the input of an external inverter/delay chain and waits for each edge to emerge at the chain output.
- The chain is typically simulated by prsim through $to_prsim/$from_prsim.
- Launches a programmed number of transitions, measures per-transition latency in clk cycles, and flags hung or mis-polarised chains.
- Sits in the Verilog side of VPI co-simulation benches as the stimulus/checker for prsim-hosted asynchronous paths.

---
 rtl/inv_chain_seq.sv | 141 ++++++++++++++
 tb/tb_inv_chain_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_chain_seq.sv
// Sequencer that toggles an external inverter/delay chain and times each edge's return.
// Flags a chain that does not settle before a run, or that does not answer within TIMEOUT cycles.
module inv_chain_seq #(
    parameter int N_STAGES    = 5,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_toggles,
    output logic             chain_in,
    input  logic             chain_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] total_latency,
    output logic [CNT_W-1:0] toggle_count
);

    localparam logic INVERTING = (N_STAGES % 2) == 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   chain_in_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [CNT_W-1:0]       remaining_q;
    logic [CNT_W-1:0]       lat_q;
    logic [CNT_W-1:0]       last_q;
    logic [CNT_W-1:0]       total_q;
    logic [CNT_W-1:0]       toggle_q;

    logic                   settled_d;
    logic [CNT_W:0]         sum_d;
    logic [CNT_W-1:0]       total_sat_d;

    // chain_out is asynchronous to clk; only the last flop is ever looked at
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], chain_out};
        end
    end

    always_comb begin
        settled_d   = sync_q[SYNC_STAGES-1] == (chain_in_q ^ INVERTING);
        sum_d       = {1'b0, total_q} + {1'b0, lat_q};
        total_sat_d = sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            chain_in_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            remaining_q <= '0;
            lat_q       <= '0;
            last_q      <= '0;
            total_q     <= '0;
            toggle_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!settled_d) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            error_q     <= 1'b0;
                            total_q     <= '0;
                            toggle_q    <= '0;
                            remaining_q <= num_toggles;
                            if (num_toggles == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_LAUNCH;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    chain_in_q <= ~chain_in_q;
                    lat_q      <= CNT_W'(1);
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // settled_d already compares against the freshly toggled chain_in
                    if (settled_d) begin
                        last_q      <= lat_q;
                        total_q     <= total_sat_d;
                        toggle_q    <= toggle_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LAUNCH;
                        end
                    end else if (lat_q == CNT_W'(TIMEOUT)) begin
                        state_q <= S_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chain_in      = chain_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign last_latency  = last_q;
    assign total_latency = total_q;
    assign toggle_count  = toggle_q;

endmodule

// File: tb/tb_inv_chain_seq.sv
// Bench for inv_chain_seq: a behavioural delay chain plus per-run arithmetic expectations.
module tb_inv_chain_seq;

    localparam int N_STAGES    = 5;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 20;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_CNT     = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_toggles;
    logic             chain_in;
    logic             chain_out;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] total_latency;
    logic [CNT_W-1:0] toggle_count;

    int   checks = 0;
    int   errors = 0;

    // behavioural chain: inverted (odd stages) copy of chain_in, delay cycles late, optionally stuck
    logic [15:0] hist;
    int          delay;
    logic        force_en;
    logic        force_val;
    logic        ci_model;

    inv_chain_seq #(
        .N_STAGES   (N_STAGES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_toggles  (num_toggles),
        .chain_in     (chain_in),
        .chain_out    (chain_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .last_latency (last_latency),
        .total_latency(total_latency),
        .toggle_count (toggle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) hist <= {hist[14:0], chain_in};

    always_comb begin
        chain_out = 1'b0;
        if (force_en)
            chain_out = force_val;
        else if (delay == 0)
            chain_out = chain_in ^ ((N_STAGES % 2) == 1);
        else
            chain_out = hist[delay-1] ^ ((N_STAGES % 2) == 1);
    end

    function automatic int exp_lat(input int d);
        return SYNC_STAGES + 1 + d;
    endfunction

    function automatic int exp_total(input int n, input int d);
        int s;
        s = n * exp_lat(d);
        return (s > MAX_CNT) ? MAX_CNT : s;
    endfunction

    task automatic settle();
        force_en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic launch(input int n);
        @(negedge clk);
        num_toggles = n[CNT_W-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // watches a run from the cycle after start until done or error, bounded
    task automatic observe(output int busy_c, output int done_c, output int cyc, output bit ok);
        busy_c = 0;
        done_c = 0;
        cyc    = 0;
        ok     = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (busy) busy_c++;
            if (done) done_c++;
            if (done || error) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_c++;
        end
    endtask

    task automatic check_run(input string tag, input int n, input int d);
        int busy_c, done_c, cyc;
        bit ok;
        delay = d;
        settle();
        launch(n);
        observe(busy_c, done_c, cyc, ok);
        ci_model = ci_model ^ n[0];
        $display("run %s: n=%0d delay=%0d busy=%0d last=%0d total=%0d toggles=%0d",
                 tag, n, d, busy_c, last_latency, total_latency, toggle_count);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_finish: run did not end within cycle budget", tag);
        end
        checks++;
        if (last_latency !== CNT_W'(exp_lat(d))) begin
            errors++;
            $display("FAIL %s_last_latency: got %0d expected %0d", tag, last_latency, exp_lat(d));
        end
        checks++;
        if (total_latency !== CNT_W'(exp_total(n, d))) begin
            errors++;
            $display("FAIL %s_total_latency: got %0d expected %0d", tag, total_latency, exp_total(n, d));
        end
        checks++;
        if (toggle_count !== CNT_W'(n)) begin
            errors++;
            $display("FAIL %s_toggle_count: got %0d expected %0d", tag, toggle_count, n);
        end
        checks++;
        if (busy_c != n * (1 + exp_lat(d))) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_c, n * (1 + exp_lat(d)));
        end
        checks++;
        if (done_c != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_c);
        end
        checks++;
        if ({error, chain_in} !== {1'b0, ci_model}) begin
            errors++;
            $display("FAIL %s_err_chain_in: got err=%b ci=%b expected err=0 ci=%b", tag, error, chain_in, ci_model);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset: busy=%b done=%b error=%b ci=%b", busy, done, error, chain_in);
        checks++;
        if ({busy, done, error, chain_in} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, chain_in});
        end
        checks++;
        if ({last_latency, total_latency, toggle_count} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", last_latency, total_latency, toggle_count);
        end
        reset = 1'b0;
        ci_model = 1'b0;
    endtask

    task automatic test_zero_delay();
        check_run("zero_delay", 4, 0);
    endtask

    task automatic test_delayed();
        check_run("delayed", 3, 5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            check_run("random", int'($urandom_range(1, 6)), int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_back_to_back();
        int busy_c, done_c, cyc;
        bit ok;
        delay = 1;
        settle();
        launch(3);
        repeat (4) @(negedge clk);
        num_toggles = 9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        observe(busy_c, done_c, cyc, ok);
        ci_model = ci_model ^ 1'b1;
        $display("back_to_back: toggles=%0d total=%0d done_pulses=%0d", toggle_count, total_latency, done_c);
        checks++;
        if (!ok || toggle_count !== CNT_W'(3) || done_c != 1) begin
            errors++;
            $display("FAIL b2b_ignore_start: got toggles=%0d done=%0d expected 3/1", toggle_count, done_c);
        end
        checks++;
        if (total_latency !== CNT_W'(exp_total(3, 1))) begin
            errors++;
            $display("FAIL b2b_total: got %0d expected %0d", total_latency, exp_total(3, 1));
        end
        // zero-toggle run: immediate done, nothing launched, counters cleared
        settle();
        launch(0);
        observe(busy_c, done_c, cyc, ok);
        $display("zero_toggles: cyc=%0d done=%0d ci=%b toggles=%0d", cyc, done_c, chain_in, toggle_count);
        checks++;
        if (!ok || cyc != 0 || done_c != 1 || busy_c != 0) begin
            errors++;
            $display("FAIL zero_done: got ok=%0d cyc=%0d done=%0d busy=%0d expected 1/0/1/0", ok, cyc, done_c, busy_c);
        end
        checks++;
        if ({chain_in, toggle_count, total_latency} !== {ci_model, CNT_W'(0), CNT_W'(0)}) begin
            errors++;
            $display("FAIL zero_state: got ci=%b toggles=%0d total=%0d expected ci=%b 0 0", chain_in, toggle_count, total_latency, ci_model);
        end
    endtask

    task automatic test_settle_error();
        check_run("pre_settle", 2, 0);
        force_en  = 1'b1;
        force_val = ci_model;
        repeat (4) @(negedge clk);
        launch(5);
        $display("settle_error: error=%b busy=%b ci=%b", error, busy, chain_in);
        checks++;
        if ({error, busy, chain_in} !== {1'b1, 1'b0, ci_model}) begin
            errors++;
            $display("FAIL settle_err: got err=%b busy=%b ci=%b expected 1 0 %b", error, busy, chain_in, ci_model);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({error, chain_in, toggle_count} !== {1'b1, ci_model, CNT_W'(2)}) begin
            errors++;
            $display("FAIL settle_sticky: got err=%b ci=%b toggles=%0d expected 1 %b 2", error, chain_in, toggle_count, ci_model);
        end
        force_en = 1'b0;
    endtask

    task automatic test_timeout();
        int busy_c, done_c, cyc;
        bit ok;
        delay = 0;
        settle();
        force_en  = 1'b1;
        force_val = ci_model ^ ((N_STAGES % 2) == 1);
        launch(3);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_start_clears: got error=%b expected 0", error);
        end
        observe(busy_c, done_c, cyc, ok);
        ci_model = ~ci_model;
        $display("timeout: busy=%0d error=%b toggles=%0d ci=%b", busy_c, error, toggle_count, chain_in);
        checks++;
        if (!ok || busy_c != 1 + TIMEOUT) begin
            errors++;
            $display("FAIL timeout_busy: got %0d expected %0d", busy_c, 1 + TIMEOUT);
        end
        checks++;
        if ({error, chain_in, toggle_count} !== {1'b1, ci_model, CNT_W'(0)} || done_c != 0) begin
            errors++;
            $display("FAIL timeout_state: got err=%b ci=%b toggles=%0d done=%0d expected 1 %b 0 0",
                     error, chain_in, toggle_count, done_c, ci_model);
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        delay = 3;
        settle();
        launch(10);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("reset_mid_run: busy=%b ci=%b toggles=%0d total=%0d", busy, chain_in, toggle_count, total_latency);
        checks++;
        if ({busy, done, error, chain_in} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 0000", {busy, done, error, chain_in});
        end
        checks++;
        if ({last_latency, total_latency, toggle_count} !== '0) begin
            errors++;
            $display("FAIL midreset_counters: got %0d/%0d/%0d expected 0", last_latency, total_latency, toggle_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ci_model = 1'b0;
        check_run("after_reset", 2, 3);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        num_toggles = '0;
        force_en    = 1'b0;
        force_val   = 1'b0;
        delay       = 0;
        ci_model    = 1'b0;
        test_reset();
        test_zero_delay();
        test_delayed();
        test_random();
        test_back_to_back();
        test_settle_error();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
